inst_mem_loader: RTL and testbench

//  Writer side of instruction memory: takes a byte stream (valid/ready), assembles 32-bit

---
 rtl/inst_mem_loader.sv | 151 +++++++++++++++
 tb/tb_inst_mem_loader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// Instruction memory loader: assembles a length-prefixed byte stream into 32-bit words and writes them.
// Define INST_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before the load is accepted.
module inst_mem_loader #(
    parameter int MEM_SIZE  = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;
    localparam logic [2:0] S_CHK    = 3'd7;

    localparam logic [31:0] BASE     = 32'(BASE_ADDR);
    localparam logic [31:0] CAPACITY = 32'(MEM_SIZE - BASE_ADDR);

    // Where a finished (or empty) program goes: straight to DONE, or via the checksum byte.
`ifdef INST_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_FINISH = S_CHK;
`else
    localparam logic [2:0] S_FINISH = S_DONE;
`endif

    logic [2:0]  state;
    logic [2:0]  next_state;
    logic [7:0]  len_hi;
    logic [15:0] word_count;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] word_reg;
    logic        xfer;
    logic [15:0] len_n;
    logic        last_word;
    logic        csum_ok;

`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
    assign csum_ok = (csum == in_data);
`else
    assign csum_ok = 1'b0;
`endif

    assign xfer      = in_valid & in_ready;
    assign len_n     = {len_hi, in_data};
    assign last_word = (word_idx + 16'd1) == word_count;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) next_state = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (xfer) next_state = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (xfer) begin
                    if (len_n == 16'd0)
                        next_state = S_FINISH;
                    else if ({16'd0, len_n} > CAPACITY)
                        next_state = S_ERR;
                    else
                        next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer && byte_cnt == 2'd3) next_state = S_WRITE;
            end
            S_WRITE: begin
                next_state = last_word ? S_FINISH : S_DATA;
            end
            S_CHK: begin
                if (xfer) next_state = csum_ok ? S_DONE : S_ERR;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= BASE;
            mem_wdata  <= 32'd0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            len_hi     <= 8'd0;
            word_count <= 16'd0;
            word_idx   <= 16'd0;
            byte_cnt   <= 2'd0;
            word_reg   <= 24'd0;
`ifdef INST_LOADER_CHECKSUM_EN
            csum       <= 8'd0;
`endif
        end else begin
            state    <= next_state;
            in_ready <= (next_state == S_LEN_HI) || (next_state == S_LEN_LO) ||
                        (next_state == S_DATA) || (next_state == S_CHK);
            mem_we   <= (next_state == S_WRITE);
            cpu_hold <= (next_state != S_DONE);
            done     <= (next_state == S_DONE);
            err      <= (next_state == S_ERR);

            if (next_state == S_LEN_HI && state != S_LEN_HI) begin
                word_idx <= 16'd0;
                byte_cnt <= 2'd0;
`ifdef INST_LOADER_CHECKSUM_EN
                csum     <= 8'd0;
`endif
            end

`ifdef INST_LOADER_CHECKSUM_EN
            if (xfer && state != S_CHK) csum <= csum ^ in_data;
`endif

            if (xfer && state == S_LEN_HI) len_hi <= in_data;
            if (xfer && state == S_LEN_LO) word_count <= len_n;

            if (xfer && state == S_DATA) begin
                word_reg <= {word_reg[15:0], in_data};
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    mem_addr  <= BASE + 32'(word_idx);
                    mem_wdata <= {word_reg, in_data};
                end
            end

            if (state == S_WRITE) word_idx <= word_idx + 16'd1;
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: expected writes are queued by the stimulus, a forked monitor checks them.
module tb_inst_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    typedef logic [7:0] byte_q_t[$];

    int  checks = 0;
    int  errors = 0;
    int  write_count = 0;
    wr_t exp_q[$];

    always #5 clk = ~clk;

    inst_mem_loader #(.MEM_SIZE(1024), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic expectWrite(input logic [31:0] addr, input logic [31:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Each byte is offered after 'gap' idle cycles and held until the loader takes it.
    task automatic applyStimulus(input byte_q_t bytes, input int gap);
        foreach (bytes[i]) begin
            int waited;
            waited = 0;
            repeat (gap) @(negedge clk);
            in_valid = 1'b1;
            in_data  = bytes[i];
            while (!in_ready && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            if (!in_ready) begin
                checkOutput("in_ready_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic waitFinish();
        int waited;
        waited = 0;
        while (!(done || err) && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!(done || err)) checkOutput("finish_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        byte_q_t s;
        int      base;

        fork
            forever begin
                @(negedge clk);
                if (mem_we) begin
                    write_count++;
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_write", 32'd1, 32'd0);
                    end else begin
                        wr_t w;
                        w = exp_q.pop_front();
                        checkOutput("write_addr", mem_addr, w.addr);
                        checkOutput("write_data", mem_wdata, w.data);
                    end
                end
            end
        join_none

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_cpu_hold", 32'(cpu_hold), 32'd1);
        checkOutput("idle_in_ready", 32'(in_ready), 32'd0);

        // Two-word program, back-to-back and then with 3-cycle gaps
        for (int g = 0; g <= 3; g += 3) begin
            base = write_count;
            expectWrite(32'd0, 32'h090C8000);
            expectWrite(32'd1, 32'h0D44001B);
            pulseStart();
            s = '{8'h00, 8'h02, 8'h09, 8'h0C, 8'h80, 8'h00, 8'h0D, 8'h44, 8'h00, 8'h1B};
`ifdef INST_LOADER_CHECKSUM_EN
            s.push_back(8'hD5);
`endif
            applyStimulus(s, g);
            waitFinish();
            @(negedge clk);
            checkOutput("prog_done", 32'(done), 32'd1);
            checkOutput("prog_err", 32'(err), 32'd0);
            checkOutput("prog_cpu_hold", 32'(cpu_hold), 32'd0);
            checkOutput("prog_in_ready", 32'(in_ready), 32'd0);
            checkOutput("prog_write_count", 32'(write_count - base), 32'd2);
        end

        // Oversized length aborts, then an empty program loads fine
        base = write_count;
        pulseStart();
        checkOutput("reload_clears_done", 32'(done), 32'd0);
        s = '{8'h04, 8'h01};
        applyStimulus(s, 0);
        waitFinish();
        repeat (3) @(negedge clk);
        checkOutput("ovf_err", 32'(err), 32'd1);
        checkOutput("ovf_done", 32'(done), 32'd0);
        checkOutput("ovf_cpu_hold", 32'(cpu_hold), 32'd1);
        checkOutput("ovf_write_count", 32'(write_count - base), 32'd0);
        pulseStart();
        s = '{8'h00, 8'h00};
`ifdef INST_LOADER_CHECKSUM_EN
        s.push_back(8'h00);
`endif
        applyStimulus(s, 0);
        waitFinish();
        @(negedge clk);
        checkOutput("empty_done", 32'(done), 32'd1);
        checkOutput("empty_err", 32'(err), 32'd0);
        checkOutput("empty_cpu_hold", 32'(cpu_hold), 32'd0);

        // Asynchronous reset in the middle of the second word
        base = write_count;
        expectWrite(32'd0, 32'h090C8000);
        pulseStart();
        s = '{8'h00, 8'h02, 8'h09, 8'h0C, 8'h80, 8'h00, 8'h0D, 8'h44};
        applyStimulus(s, 0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("arst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("arst_cpu_hold", 32'(cpu_hold), 32'd1);
        checkOutput("arst_done", 32'(done), 32'd0);
        checkOutput("arst_mem_addr", mem_addr, 32'd0);
        checkOutput("arst_mem_wdata", mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("arst_write_count", 32'(write_count - base), 32'd1);
        checkOutput("arst_idle_done", 32'(done), 32'd0);
        checkOutput("arst_idle_cpu_hold", 32'(cpu_hold), 32'd1);

`ifdef INST_LOADER_CHECKSUM_EN
        // XOR of 00 01 33 FF FF FD is CF: matching byte loads, zero byte aborts
        expectWrite(32'd0, 32'h33FFFFFD);
        pulseStart();
        s = '{8'h00, 8'h01, 8'h33, 8'hFF, 8'hFF, 8'hFD, 8'hCF};
        applyStimulus(s, 0);
        waitFinish();
        @(negedge clk);
        checkOutput("chk_good_done", 32'(done), 32'd1);
        checkOutput("chk_good_err", 32'(err), 32'd0);
        expectWrite(32'd0, 32'h33FFFFFD);
        pulseStart();
        s = '{8'h00, 8'h01, 8'h33, 8'hFF, 8'hFF, 8'hFD, 8'h00};
        applyStimulus(s, 0);
        waitFinish();
        @(negedge clk);
        checkOutput("chk_bad_err", 32'(err), 32'd1);
        checkOutput("chk_bad_done", 32'(done), 32'd0);
        checkOutput("chk_bad_cpu_hold", 32'(cpu_hold), 32'd1);
        checkOutput("chk_bad_addr_kept", mem_addr, 32'd0);
        checkOutput("chk_bad_data_kept", mem_wdata, 32'h33FFFFFD);
`endif

        repeat (2) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
